// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 datapath: accepts a block, steps the round
// index while capturing round results on key_valid, then presents the block.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 4,
  parameter int DATA_W     = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mode,
  output logic [DATA_W-1:0] data_in,
  output logic [CNT_W-1:0]  count_out,
  output logic              key_req,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] round_result,
  output logic [DATA_W-1:0] data_to_store,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              abort,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_in_q, data_in_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic                key_req_q, key_req_d;
  logic                out_valid_q, out_valid_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    term_cnt;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and out_valid/out_data stay
  // stable until the transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_in_q   <= '0;
      store_q     <= '0;
      key_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_in_q   <= data_in_d;
      store_q     <= store_d;
      key_req_q   <= key_req_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
    end
  end

  assign term_cnt = mode_q ? '0 : CNT_W'(NUM_ROUNDS);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_in_d   = data_in_q;
    store_d     = store_q;
    key_req_d   = key_req_q;
    out_valid_d = out_valid_q;
    mode_d      = mode_q;
    // abort wins over any capture or handshake in the same cycle
    if (abort) begin
      state_d     = IDLE;
      cnt_d       = '0;
      key_req_d   = 1'b0;
      out_valid_d = 1'b0;
      mode_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_in_d = in_data;
            mode_d    = mode;
            cnt_d     = mode ? CNT_W'(NUM_ROUNDS) : '0;
            key_req_d = 1'b1;
            state_d   = ROUND;
          end
        end
        ROUND: begin
          if (key_valid) begin
            store_d = round_result;
            if (cnt_q == term_cnt) begin
              key_req_d   = 1'b0;
              out_valid_d = 1'b1;
              state_d     = DONE;
            end else if (mode_q) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    in_ready      = (state_q == IDLE) && !rst && !abort;
    busy          = (state_q != IDLE);
    data_in       = data_in_q;
    count_out     = cnt_q;
    key_req       = key_req_q;
    data_to_store = store_q;
    out_valid     = out_valid_q;
    out_data      = store_q;
    state_dbg     = state_q;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencer for the AES-128 round datapath; drives the byte-substitution stage and its round-state register.
- Accepts a 128-bit block over a valid/ready handshake and walks the round counter through all rounds, waiting on the key-schedule handshake each round.
- Captures each round result back into the state register and presents the finished block on an output valid/ready handshake.
- Sits between the SD-card data path (upstream/downstream) and the combinational round logic plus key expansion.

Parameters:
- NUM_ROUNDS, 10, index of the last round; count_out spans 0..NUM_ROUNDS.
- CNT_W, 4, width of count_out; must satisfy 2^CNT_W > NUM_ROUNDS.
- DATA_W, 128, block width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream block available.
- in_ready  out  1  controller can accept a block.
- in_data  in  DATA_W  plaintext/ciphertext block.
- mode  in  1  sampled with in_data; 0 = encrypt, 1 = decrypt.
- data_in  out  DATA_W  registered copy of the accepted block, to the round datapath.
- count_out  out  CNT_W  current round index, to the round datapath.
- key_req  out  1  requests the round key for count_out.
- key_valid  in  1  round key for count_out is present on the key bus this cycle.
- round_result  in  DATA_W  combinational datapath output for the current round.
- data_to_store  out  DATA_W  round-state register, fed back to the datapath.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  finished block valid.
- out_ready  in  1  downstream accepts the block.
- out_data  out  DATA_W  equals data_to_store while out_valid is high.
- abort  in  1  synchronous cancel.

Behaviour:
- Reset, asynchronous: state=IDLE, count_out=0, data_in=0, data_to_store=0, key_req=0, out_valid=0, busy=0, mode_q=0. in_ready=1 once rst deasserts.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: register data_in<=in_data and mode_q<=mode. Set count_out<=0 when mode=0, or NUM_ROUNDS when mode=1. Set key_req<=1 and go to ROUND.
  - key_valid and out_ready are ignored in this state.
- ROUND:
  - in_ready=0 and key_req=1.
  - Each cycle with key_valid=1: data_to_store<=round_result.
  - If count_out is the terminal value (NUM_ROUNDS for encrypt, 0 for decrypt), set key_req<=0 and go to DONE.
  - Otherwise step count_out by +1 (encrypt) or -1 (decrypt).
  - With key_valid=0, hold every register.
  - count_out never wraps: it never leaves 0..NUM_ROUNDS.
- DONE:
  - out_valid=1, out_data=data_to_store, both held stable until out_ready=1.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE, count_out<=0.
  - The next block is not accepted in the same cycle; in_ready rises the following cycle.
- Latency with key_valid tied high: in_valid accepted at cycle 0; round captures at cycles 1..NUM_ROUNDS+1 (11 captures); out_valid=1 from cycle NUM_ROUNDS+2 (12).
- Throughput: one block per NUM_ROUNDS+3 cycles with out_ready held high.
- abort: in any state, the next edge returns to the reset values except data_in and data_to_store, which hold. abort has priority over every other event in that cycle, including a key_valid capture or an output handshake.
- in_valid while busy: ignored; in_ready=0 guarantees no handshake occurs.
- A mode change after acceptance has no effect; mode_q governs the whole block.
- rst mid-round: immediate return to the reset values; the partial block is discarded, and no out_valid is produced for it.

Test Plan:
- Encrypt, key_valid=1 always; bench model round_result = data_to_store ^ {124'b0,count_out}, with in_data = 128'h0. Required: count_out sequence 0,1,...,10; out_valid at cycle 12; out_data = XOR of 0..10 = 128'h...0B.
- Decrypt, mode=1, same model. Required: count_out sequence 10,9,...,0; out_valid at cycle 12; out_data = 128'h...0B.
- key_valid pattern 1,0,0,1,1,... (two-cycle stall after round 0). Required: count_out holds at 1 for 3 cycles; data_to_store unchanged during the stall; out_valid at cycle 14.
- out_ready held 0 for 5 cycles after out_valid. Required: out_valid and out_data stable throughout; in_ready=0; in_valid pulses during DONE ignored; in_ready=1 one cycle after the handshake.
- abort asserted in ROUND at count_out=4, coincident with key_valid=1. Required: next cycle state=IDLE, count_out=0, key_req=0, data_to_store not updated by that key_valid; no out_valid ever asserted for the block.
- rst pulsed asynchronously mid-DONE, between clock edges. Required: out_valid, busy, key_req drop to 0 immediately; count_out=0; after release, a fresh encrypt block completes normally in 12 cycles.
